stage_memory: RTL and testbench

- Memory stage of the five-stage pipeline, directly upstream of the writeback stage.
- Takes the X/M latch contents and performs lw/sw through a req/ack data-memory handshake.
- Stalls the front of the pipeline while an access is outstanding, and owns the M/W pipeline latch that feeds writeback (insn, o_in, d_in, write_exception).
- Bypasses writeback-stage results into store data, and converts an unanswered access into a bus-error exception.

---
 rtl/stage_memory_pkg.sv | 19 +
 rtl/stage_memory_mem_controls.sv | 24 ++
 rtl/stage_memory.sv | 169 ++++++++++++++++
 tb/tb_stage_memory.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/stage_memory_pkg.sv
// Shared constants for the memory stage: opcodes, special registers, FSM encoding.
package stage_memory_pkg;

    localparam logic [4:0] OP_RTYPE = 5'b00000;
    localparam logic [4:0] OP_ADDI  = 5'b00101;
    localparam logic [4:0] OP_SW    = 5'b00111;
    localparam logic [4:0] OP_LW    = 5'b01000;
    localparam logic [4:0] OP_JAL   = 5'b00011;
    localparam logic [4:0] OP_SETX  = 5'b10101;

    localparam logic [4:0] RSTATUS_REG = 5'd30;
    localparam logic [4:0] RA_REG      = 5'd31;

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_ACCESS = 1'b1;

    localparam logic [31:0] DEFAULT_BUS_ERR_CODE = 32'd6;

endpackage

// File: rtl/stage_memory_mem_controls.sv
// Opcode decode for memory-stage control; the writeback stage uses the same decode.
module stage_memory_mem_controls
    import stage_memory_pkg::*;
(
    input  logic [31:0] i_insn,
    input  logic        i_valid,
    output logic        o_lw,
    output logic        o_sw,
    output logic        o_mem_op,
    output logic [4:0]  o_rd
);

    logic [4:0]  w_opcode;
    logic [21:0] w_unused_insn;

    assign w_opcode      = i_insn[31:27];
    assign o_rd          = i_insn[26:22];
    assign w_unused_insn = i_insn[21:0];

    assign o_lw     = (w_opcode == OP_LW);
    assign o_sw     = (w_opcode == OP_SW);
    assign o_mem_op = i_valid & (o_lw | o_sw);

endmodule

// File: rtl/stage_memory.sv
// Memory stage: lw/sw over a req/ack dmem handshake with timeout, owns the M/W latch.
// Define STAGE_MEMORY_BYPASS_EN to forward writeback results into store data.
module stage_memory
    import stage_memory_pkg::*;
#(
    parameter int unsigned ADDR_W         = 12,
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter logic [31:0] BUS_ERR_CODE   = DEFAULT_BUS_ERR_CODE
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [31:0]       xm_insn,
    input  logic [31:0]       xm_o,
    input  logic [31:0]       xm_b,
    input  logic              xm_exception,
    input  logic              xm_valid,
    input  logic [31:0]       w_data_writeReg,
    input  logic [4:0]        w_ctrl_writeReg,
    input  logic              w_ctrl_writeEnable,
    output logic              dmem_req,
    output logic              dmem_wren,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [31:0]       dmem_data,
    input  logic              dmem_ack,
    input  logic [31:0]       dmem_q,
    output logic              mem_stall,
    output logic [31:0]       mw_insn,
    output logic [31:0]       mw_o,
    output logic [31:0]       mw_d,
    output logic              mw_exception,
    output logic              mw_valid
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(TIMEOUT_CYCLES - 1);

    logic              w_lw, w_sw, w_mem_op;
    logic [4:0]        w_rd;
    logic [31:0]       w_store_data;

    logic [0:0]        r_state, w_state_next;
    logic [CNT_W-1:0]  r_count, w_count_next;
    logic              r_req, w_req_next;
    logic              r_wren, w_wren_next;
    logic [ADDR_W-1:0] r_addr, w_addr_next;
    logic [31:0]       r_data, w_data_next;
    logic [31:0]       r_mw_insn, w_mw_insn_next;
    logic [31:0]       r_mw_o, w_mw_o_next;
    logic [31:0]       r_mw_d, w_mw_d_next;
    logic              r_mw_exc, w_mw_exc_next;
    logic              r_mw_valid, w_mw_valid_next;

    stage_memory_mem_controls u_mem_controls (
        .i_insn   (xm_insn),
        .i_valid  (xm_valid),
        .o_lw     (w_lw),
        .o_sw     (w_sw),
        .o_mem_op (w_mem_op),
        .o_rd     (w_rd)
    );

`ifdef STAGE_MEMORY_BYPASS_EN
    assign w_store_data = (w_ctrl_writeEnable && (w_ctrl_writeReg == w_rd) && (w_rd != 5'd0))
                          ? w_data_writeReg : xm_b;
`else
    logic w_unused_bypass;
    assign w_unused_bypass = ^{w_data_writeReg, w_ctrl_writeReg, w_ctrl_writeEnable, w_rd};
    assign w_store_data    = xm_b;
`endif

    always_comb begin
        w_state_next    = r_state;
        w_count_next    = r_count;
        w_req_next      = r_req;
        w_wren_next     = r_wren;
        w_addr_next     = r_addr;
        w_data_next     = r_data;
        // Bubble unless a transfer into the latch is decided below.
        w_mw_insn_next  = 32'd0;
        w_mw_o_next     = 32'd0;
        w_mw_d_next     = 32'd0;
        w_mw_exc_next   = 1'b0;
        w_mw_valid_next = 1'b0;
        mem_stall       = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (w_mem_op) begin
                    mem_stall    = 1'b1;
                    w_state_next = ST_ACCESS;
                    w_count_next = '0;
                    w_req_next   = 1'b1;
                    w_wren_next  = w_sw;
                    w_addr_next  = xm_o[ADDR_W-1:0];
                    w_data_next  = w_store_data;
                end else begin
                    w_mw_insn_next  = xm_insn;
                    w_mw_o_next     = xm_o;
                    w_mw_exc_next   = xm_exception;
                    w_mw_valid_next = xm_valid;
                end
            end
            ST_ACCESS: begin
                mem_stall = ~dmem_ack;
                if (dmem_ack) begin
                    w_state_next    = ST_IDLE;
                    w_req_next      = 1'b0;
                    w_mw_insn_next  = xm_insn;
                    w_mw_o_next     = xm_o;
                    w_mw_d_next     = w_lw ? dmem_q : 32'd0;
                    w_mw_exc_next   = xm_exception;
                    w_mw_valid_next = 1'b1;
                end else if (r_count == LAST_COUNT) begin
                    w_state_next    = ST_IDLE;
                    w_req_next      = 1'b0;
                    w_mw_insn_next  = xm_insn;
                    w_mw_o_next     = BUS_ERR_CODE;
                    w_mw_d_next     = BUS_ERR_CODE;
                    w_mw_exc_next   = 1'b1;
                    w_mw_valid_next = 1'b1;
                end else begin
                    w_count_next = r_count + CNT_W'(1);
                end
            end
            default: begin
                w_state_next = ST_IDLE;
                w_req_next   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_count    <= '0;
            r_req      <= 1'b0;
            r_wren     <= 1'b0;
            r_addr     <= '0;
            r_data     <= 32'd0;
            r_mw_insn  <= 32'd0;
            r_mw_o     <= 32'd0;
            r_mw_d     <= 32'd0;
            r_mw_exc   <= 1'b0;
            r_mw_valid <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_count    <= w_count_next;
            r_req      <= w_req_next;
            r_wren     <= w_wren_next;
            r_addr     <= w_addr_next;
            r_data     <= w_data_next;
            r_mw_insn  <= w_mw_insn_next;
            r_mw_o     <= w_mw_o_next;
            r_mw_d     <= w_mw_d_next;
            r_mw_exc   <= w_mw_exc_next;
            r_mw_valid <= w_mw_valid_next;
        end
    end

    assign dmem_req     = r_req;
    assign dmem_wren    = r_wren;
    assign dmem_addr    = r_addr;
    assign dmem_data    = r_data;
    assign mw_insn      = r_mw_insn;
    assign mw_o         = r_mw_o;
    assign mw_d         = r_mw_d;
    assign mw_exception = r_mw_exc;
    assign mw_valid     = r_mw_valid;

endmodule

// File: tb/tb_stage_memory.sv
// Directed bench for stage_memory with a short timeout (4 cycles).
module tb_stage_memory;

    localparam int unsigned ADDR_W = 12;

    logic              clock = 1'b0;
    logic              reset;
    logic [31:0]       xm_insn, xm_o, xm_b;
    logic              xm_exception, xm_valid;
    logic [31:0]       w_data_writeReg;
    logic [4:0]        w_ctrl_writeReg;
    logic              w_ctrl_writeEnable;
    logic              dmem_req, dmem_wren;
    logic [ADDR_W-1:0] dmem_addr;
    logic [31:0]       dmem_data;
    logic              dmem_ack;
    logic [31:0]       dmem_q;
    logic              mem_stall;
    logic [31:0]       mw_insn, mw_o, mw_d;
    logic              mw_exception, mw_valid;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] lw7, sw5, sw0, lw2, lw4, add3;
    logic [31:0] exp_bypass;

    stage_memory #(
        .ADDR_W         (ADDR_W),
        .TIMEOUT_CYCLES (4),
        .BUS_ERR_CODE   (32'd6)
    ) dut (
        .clock              (clock),
        .reset              (reset),
        .xm_insn            (xm_insn),
        .xm_o               (xm_o),
        .xm_b               (xm_b),
        .xm_exception       (xm_exception),
        .xm_valid           (xm_valid),
        .w_data_writeReg    (w_data_writeReg),
        .w_ctrl_writeReg    (w_ctrl_writeReg),
        .w_ctrl_writeEnable (w_ctrl_writeEnable),
        .dmem_req           (dmem_req),
        .dmem_wren          (dmem_wren),
        .dmem_addr          (dmem_addr),
        .dmem_data          (dmem_data),
        .dmem_ack           (dmem_ack),
        .dmem_q             (dmem_q),
        .mem_stall          (mem_stall),
        .mw_insn            (mw_insn),
        .mw_o               (mw_o),
        .mw_d               (mw_d),
        .mw_exception       (mw_exception),
        .mw_valid           (mw_valid)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] mk(input logic [4:0] op, input logic [4:0] rd);
        return {op, rd, 22'h0};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        lw7  = mk(5'b01000, 5'd7);
        sw5  = mk(5'b00111, 5'd5);
        sw0  = mk(5'b00111, 5'd0);
        lw2  = mk(5'b01000, 5'd2);
        lw4  = mk(5'b01000, 5'd4);
        add3 = mk(5'b00000, 5'd3) | 32'h0000_1234;
`ifdef STAGE_MEMORY_BYPASS_EN
        exp_bypass = 32'h99;
`else
        exp_bypass = 32'h11;
`endif

        reset = 1'b0;
        xm_insn = '0; xm_o = '0; xm_b = '0; xm_exception = 1'b0; xm_valid = 1'b0;
        w_data_writeReg = '0; w_ctrl_writeReg = '0; w_ctrl_writeEnable = 1'b0;
        dmem_ack = 1'b0; dmem_q = '0;
        #12;
        check("rst_req", {31'd0, dmem_req}, 32'd0);
        check("rst_mw_valid", {31'd0, mw_valid}, 32'd0);
        check("rst_mw_insn", mw_insn, 32'd0);
        check("rst_stall", {31'd0, mem_stall}, 32'd0);
        reset = 1'b1;
        step();

        // Non-memory instruction passes straight through
        xm_insn = add3; xm_o = 32'h15; xm_valid = 1'b1;
        #1 check("add_stall", {31'd0, mem_stall}, 32'd0);
        step();
        check("add_mw_insn", mw_insn, add3);
        check("add_mw_o", mw_o, 32'h15);
        check("add_mw_d", mw_d, 32'd0);
        check("add_mw_valid", {31'd0, mw_valid}, 32'd1);
        check("add_req", {31'd0, dmem_req}, 32'd0);

        // lw with ack two cycles after req: stall high for three cycles
        xm_insn = lw7; xm_o = 32'h40;
        #1 check("lw_stall_c0", {31'd0, mem_stall}, 32'd1);
        step();
        check("lw_req", {31'd0, dmem_req}, 32'd1);
        check("lw_addr", {20'd0, dmem_addr}, 32'h040);
        check("lw_wren", {31'd0, dmem_wren}, 32'd0);
        check("lw_bubble0", {31'd0, mw_valid}, 32'd0);
        check("lw_bubble0_insn", mw_insn, 32'd0);
        check("lw_stall_c1", {31'd0, mem_stall}, 32'd1);
        step();
        check("lw_bubble1", {31'd0, mw_valid}, 32'd0);
        check("lw_stall_c2", {31'd0, mem_stall}, 32'd1);
        step();
        dmem_ack = 1'b1; dmem_q = 32'hDEAD_BEEF;
        #1 check("lw_stall_ack", {31'd0, mem_stall}, 32'd0);
        step();
        dmem_ack = 1'b0;
        check("lw_mw_d", mw_d, 32'hDEAD_BEEF);
        check("lw_mw_valid", {31'd0, mw_valid}, 32'd1);
        check("lw_mw_insn", mw_insn, lw7);
        check("lw_mw_o", mw_o, 32'h40);
        check("lw_req_drop", {31'd0, dmem_req}, 32'd0);

        // sw rd=5 with writeback writing r5; ack in first ACCESS cycle
        xm_insn = sw5; xm_o = 32'h123; xm_b = 32'h11;
        w_ctrl_writeEnable = 1'b1; w_ctrl_writeReg = 5'd5; w_data_writeReg = 32'h99;
        step();
        check("sw5_data", dmem_data, exp_bypass);
        check("sw5_wren", {31'd0, dmem_wren}, 32'd1);
        check("sw5_addr", {20'd0, dmem_addr}, 32'h123);
        dmem_ack = 1'b1;
        #1 check("sw5_stall_ack", {31'd0, mem_stall}, 32'd0);
        step();
        dmem_ack = 1'b0;
        check("sw5_mw_d", mw_d, 32'd0);
        check("sw5_mw_valid", {31'd0, mw_valid}, 32'd1);
        check("sw5_mw_insn", mw_insn, sw5);

        // sw rd=0 never takes the bypass
        xm_insn = sw0; xm_o = 32'h124; w_ctrl_writeReg = 5'd0;
        step();
        check("sw0_data", dmem_data, 32'h11);
        dmem_ack = 1'b1;
        step();
        dmem_ack = 1'b0;
        w_ctrl_writeEnable = 1'b0;
        check("sw0_mw_valid", {31'd0, mw_valid}, 32'd1);

        // Back-to-back lw right after a completion
        xm_insn = lw2; xm_o = 32'h8;
        #1 check("b2b_stall", {31'd0, mem_stall}, 32'd1);
        step();
        check("b2b_req", {31'd0, dmem_req}, 32'd1);
        check("b2b_addr", {20'd0, dmem_addr}, 32'h008);
        dmem_ack = 1'b1; dmem_q = 32'h1234_5678;
        step();
        dmem_ack = 1'b0;
        check("b2b_mw_d", mw_d, 32'h1234_5678);
        check("b2b_mw_insn", mw_insn, lw2);

        // lw with no ack times out after four ACCESS cycles
        xm_insn = lw4; xm_o = 32'h20;
        for (int i = 0; i < 4; i++) begin
            step();
            check($sformatf("to_req_%0d", i), {31'd0, dmem_req}, 32'd1);
            check($sformatf("to_bubble_%0d", i), {31'd0, mw_valid}, 32'd0);
        end
        step();
        check("to_req_drop", {31'd0, dmem_req}, 32'd0);
        check("to_exc", {31'd0, mw_exception}, 32'd1);
        check("to_mw_o", mw_o, 32'd6);
        check("to_mw_d", mw_d, 32'd6);
        check("to_mw_valid", {31'd0, mw_valid}, 32'd1);
        check("to_mw_insn", mw_insn, lw4);
        xm_insn = '0; xm_o = '0; xm_valid = 1'b0;
        dmem_ack = 1'b1; dmem_q = 32'hBAD0_BAD0;
        step();
        dmem_ack = 1'b0;
        check("late_ack_valid", {31'd0, mw_valid}, 32'd0);
        check("late_ack_d", mw_d, 32'd0);
        check("late_ack_exc", {31'd0, mw_exception}, 32'd0);
        check("late_ack_req", {31'd0, dmem_req}, 32'd0);

        // Reset in the middle of an ACCESS abandons it
        xm_insn = sw5; xm_o = 32'h3FF; xm_b = 32'h55; xm_valid = 1'b1;
        step();
        check("rst_mid_req_pre", {31'd0, dmem_req}, 32'd1);
        #2 reset = 1'b0;
        #1;
        check("rst_mid_req", {31'd0, dmem_req}, 32'd0);
        check("rst_mid_addr", {20'd0, dmem_addr}, 32'd0);
        check("rst_mid_data", dmem_data, 32'd0);
        check("rst_mid_wren", {31'd0, dmem_wren}, 32'd0);
        check("rst_mid_mw_valid", {31'd0, mw_valid}, 32'd0);
        xm_valid = 1'b0; xm_insn = '0; xm_o = '0;
        #2 reset = 1'b1;
        dmem_ack = 1'b1;
        step();
        dmem_ack = 1'b0;
        check("post_rst_req", {31'd0, dmem_req}, 32'd0);
        check("post_rst_stall", {31'd0, mem_stall}, 32'd0);
        check("post_rst_mw_valid", {31'd0, mw_valid}, 32'd0);
        check("post_rst_mw_d", mw_d, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
